// File: rtl/if_stream_monitor_pkg.sv
// Shared constants for the fetch->decode stream monitor: error bit positions,
// event counter slots and cross-cover slots.
package if_mon_pkg;

  localparam int ERR_W              = 4;
  localparam int ERR_RESTART_MULTI  = 0;
  localparam int ERR_VALID_UNSTABLE = 1;
  localparam int ERR_FLUSH_VALID    = 2;
  localparam int ERR_LANE_HOLE      = 3;

  localparam int NUM_EVT       = 8;
  localparam int EVT_FLUSH     = 0;
  localparam int EVT_INV_PRED  = 1;
  localparam int EVT_INV_INSTR = 2;
  localparam int EVT_CALL      = 3;
  localparam int EVT_RET       = 4;
  localparam int EVT_XFER      = 5;
  localparam int EVT_STALL     = 6;
  localparam int EVT_LANES     = 7;

  localparam int NUM_COV            = 6;
  localparam int COV_FLUSH_MISS     = 0;
  localparam int COV_INV_PRED_MISS  = 1;
  localparam int COV_INV_INSTR_MISS = 2;
  localparam int COV_PARTIAL_1      = 3;
  localparam int COV_PARTIAL_2      = 4;
  localparam int COV_PARTIAL_3      = 5;

endpackage

// File: rtl/if_stream_monitor_if.sv
// Fetch->decode boundary bundle; the master side is the fetch stage, the
// slave side is any passive observer (it only ever reads).
interface if_stream_monitor_if #(
  parameter int LANES    = 2,
  parameter int PACKET_W = 64
);
  logic                      valid_o;
  logic                      ready_in;
  logic [LANES*PACKET_W-1:0] data_out;
  logic [LANES-1:0]          lane_valid_i;
  logic                      must_flush;
  logic                      invalid_prediction;
  logic                      invalid_instruction;
  logic                      is_return_in;
  logic                      is_jumpl;
  logic                      hit_cache;
  logic                      miss;
  logic                      partial_access;
  logic [1:0]                partial_type;

  modport master (
    output valid_o, data_out, lane_valid_i, must_flush, invalid_prediction,
           invalid_instruction, is_return_in, is_jumpl, hit_cache, miss,
           partial_access, partial_type,
    input  ready_in
  );

  modport slave (
    input valid_o, ready_in, data_out, lane_valid_i, must_flush,
          invalid_prediction, invalid_instruction, is_return_in, is_jumpl,
          hit_cache, miss, partial_access, partial_type
  );
endinterface

// File: rtl/if_stream_monitor_sat_counter.sv
// Saturating up-counter: adds inc_i each cycle, sticks at all-ones.
// Latency 1 cycle; synchronous clear_i wins over the increment.
module sat_counter #(
  parameter int W     = 16,
  parameter int INC_W = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic [INC_W-1:0] inc_i,
  output logic [W-1:0]     cnt_o
);

  localparam int             SW  = ((W > INC_W) ? W : INC_W) + 1;
  localparam logic [SW-1:0]  MAX = SW'({W{1'b1}});

  logic [SW-1:0] sum;
  assign sum = SW'(cnt_o) + SW'(inc_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_o <= '0;
    end else if (clear_i) begin
      cnt_o <= '0;
    end else if (sum > MAX) begin
      cnt_o <= '1;
    end else begin
      cnt_o <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/if_stream_monitor.sv
// Passive fetch->decode protocol monitor: sticky errors, first-error record, event counters.
// Latency 1 cycle, never drives ready (no backpressure); IFMON_COVER_EN adds cross-cover counters.
module if_stream_monitor
  import if_mon_pkg::*;
#(
  parameter int LANES    = 2,
  parameter int PACKET_W = 64,
  parameter int CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear_i,
  if_stream_monitor_if.slave       mon,
  output logic [ERR_W-1:0]         err_flags_o,
  output logic                     err_any_o,
  output logic [ERR_W-1:0]         first_err_o,
  output logic [CNT_W-1:0]         first_err_cycle_o,
  output logic [NUM_EVT*CNT_W-1:0] evt_cnt_o,
  output logic [NUM_COV*CNT_W-1:0] cov_cnt_o
);

  localparam int PC_W = $clog2(LANES + 1);

  logic [ERR_W-1:0]          det;
  logic                      hold_vld;
  logic [LANES*PACKET_W-1:0] hold_data;
  logic [LANES-1:0]          hold_lanes;
  logic [LANES-1:0]          lanes_p1;
  logic [PC_W-1:0]           lane_pop;
  logic [CNT_W-1:0]          cycle_cnt;
  logic [PC_W-1:0]           evt_inc [NUM_EVT];
  logic                      xfer;
  logic                      stall;

  assign xfer     = mon.valid_o && mon.ready_in;
  assign stall    = mon.valid_o && !mon.ready_in;
  assign lanes_p1 = mon.lane_valid_i + LANES'(1);

  always_comb begin
    lane_pop = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_pop = lane_pop + PC_W'(mon.lane_valid_i[i]);
    end
  end

  // A contiguous 0..01..1 mask has no bit in common with itself plus one.
  always_comb begin
    det = '0;
    det[ERR_RESTART_MULTI]  = (mon.invalid_prediction && mon.invalid_instruction) ||
                              (mon.invalid_prediction && mon.is_return_in) ||
                              (mon.invalid_instruction && mon.is_return_in);
    det[ERR_VALID_UNSTABLE] = hold_vld && !mon.must_flush &&
                              (!mon.valid_o || (mon.data_out != hold_data) ||
                               (mon.lane_valid_i != hold_lanes));
    det[ERR_FLUSH_VALID]    = mon.must_flush && mon.valid_o;
    det[ERR_LANE_HOLE]      = mon.valid_o && ((mon.lane_valid_i == '0) ||
                              ((mon.lane_valid_i & lanes_p1) != '0));
  end

  assign err_any_o = |err_flags_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld          <= 1'b0;
      hold_data         <= '0;
      hold_lanes        <= '0;
      err_flags_o       <= '0;
      first_err_o       <= '0;
      first_err_cycle_o <= '0;
    end else if (clear_i) begin
      hold_vld          <= 1'b0;
      hold_data         <= '0;
      hold_lanes        <= '0;
      err_flags_o       <= '0;
      first_err_o       <= '0;
      first_err_cycle_o <= '0;
    end else begin
      hold_vld <= stall && !mon.must_flush;
      if (stall) begin
        hold_data  <= mon.data_out;
        hold_lanes <= mon.lane_valid_i;
      end
      err_flags_o <= err_flags_o | det;
      if (!err_any_o && (det != '0)) begin
        first_err_o       <= det;
        first_err_cycle_o <= cycle_cnt;
      end
    end
  end

  sat_counter #(.W(CNT_W), .INC_W(1)) u_cycle (
    .clk     (clk),
    .rst     (rst),
    .clear_i (clear_i),
    .inc_i   (1'b1),
    .cnt_o   (cycle_cnt)
  );

  always_comb begin
    evt_inc[EVT_FLUSH]     = PC_W'(mon.must_flush);
    evt_inc[EVT_INV_PRED]  = PC_W'(mon.invalid_prediction);
    evt_inc[EVT_INV_INSTR] = PC_W'(mon.invalid_instruction);
    evt_inc[EVT_CALL]      = PC_W'(mon.is_jumpl);
    evt_inc[EVT_RET]       = PC_W'(mon.is_return_in);
    evt_inc[EVT_XFER]      = PC_W'(xfer);
    evt_inc[EVT_STALL]     = PC_W'(stall);
    evt_inc[EVT_LANES]     = xfer ? lane_pop : '0;
  end

  for (genvar g = 0; g < NUM_EVT; g++) begin : g_evt
    sat_counter #(.W(CNT_W), .INC_W(PC_W)) u_evt (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .inc_i   (evt_inc[g]),
      .cnt_o   (evt_cnt_o[g*CNT_W +: CNT_W])
    );
  end

`ifdef IFMON_COVER_EN
  logic [NUM_COV-1:0] cov_inc;
  logic               part_hit;

  assign part_hit                    = mon.partial_access && mon.hit_cache;
  assign cov_inc[COV_FLUSH_MISS]     = mon.must_flush && mon.miss;
  assign cov_inc[COV_INV_PRED_MISS]  = mon.invalid_prediction && mon.miss;
  assign cov_inc[COV_INV_INSTR_MISS] = mon.invalid_instruction && mon.miss;
  assign cov_inc[COV_PARTIAL_1]      = part_hit && (mon.partial_type == 2'd1);
  assign cov_inc[COV_PARTIAL_2]      = part_hit && (mon.partial_type == 2'd2);
  assign cov_inc[COV_PARTIAL_3]      = part_hit && (mon.partial_type == 2'd3);

  for (genvar c = 0; c < NUM_COV; c++) begin : g_cov
    sat_counter #(.W(CNT_W), .INC_W(1)) u_cov (
      .clk     (clk),
      .rst     (rst),
      .clear_i (clear_i),
      .inc_i   (cov_inc[c]),
      .cnt_o   (cov_cnt_o[c*CNT_W +: CNT_W])
    );
  end
`else
  logic unused_cover;
  assign unused_cover = ^{mon.hit_cache, mon.miss, mon.partial_access, mon.partial_type};
  assign cov_cnt_o    = '0;
`endif

endmodule

// File: tb/tb_if_stream_monitor.sv
// Bench for if_stream_monitor: directed scenarios plus a randomized run against
// a behavioural model; a second small instance (LANES=4, CNT_W=4) covers saturation and wide lane masks.
module tb_if_stream_monitor;

  logic clk;
  logic rst;
  logic clear_i;

  if_stream_monitor_if #(.LANES(2), .PACKET_W(64)) fi ();
  if_stream_monitor_if #(.LANES(4), .PACKET_W(8))  fs ();

  logic [3:0]   err_flags, first_err, s_err_flags, s_first_err;
  logic         err_any, s_err_any;
  logic [15:0]  first_cyc;
  logic [3:0]   s_first_cyc;
  logic [127:0] evt;
  logic [95:0]  cov;
  logic [31:0]  s_evt;
  logic [23:0]  s_cov;

  if_stream_monitor #(.LANES(2), .PACKET_W(64), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .clear_i(clear_i), .mon(fi),
    .err_flags_o(err_flags), .err_any_o(err_any), .first_err_o(first_err),
    .first_err_cycle_o(first_cyc), .evt_cnt_o(evt), .cov_cnt_o(cov)
  );

  if_stream_monitor #(.LANES(4), .PACKET_W(8), .CNT_W(4)) u_dut_small (
    .clk(clk), .rst(rst), .clear_i(clear_i), .mon(fs),
    .err_flags_o(s_err_flags), .err_any_o(s_err_any), .first_err_o(s_first_err),
    .first_err_cycle_o(s_first_cyc), .evt_cnt_o(s_evt), .cov_cnt_o(s_cov)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the 2-lane, 16-bit-counter instance.
  localparam int MAXC = 65535;
  logic [3:0]   m_err, m_first;
  int           m_cyc, m_first_cyc;
  int           m_evt [8];
  int           m_cov [6];
  logic         m_hold_vld;
  logic [127:0] m_hold_data;
  logic [1:0]   m_hold_lanes;

  function automatic int sat(input int v);
    return (v > MAXC) ? MAXC : v;
  endfunction

  task automatic model_reset();
    m_err = '0; m_first = '0; m_cyc = 0; m_first_cyc = 0;
    for (int k = 0; k < 8; k++) m_evt[k] = 0;
    for (int k = 0; k < 6; k++) m_cov[k] = 0;
    m_hold_vld = 1'b0; m_hold_data = '0; m_hold_lanes = '0;
  endtask

  task automatic model_step();
    logic [3:0] d;
    int nr, pc;
    bit hole, xf, st;
    if (clear_i) begin
      model_reset();
      return;
    end
    d  = '0;
    nr = int'(fi.invalid_prediction) + int'(fi.invalid_instruction) + int'(fi.is_return_in);
    if (nr >= 2) d[0] = 1'b1;
    if (m_hold_vld && !fi.must_flush &&
        (!fi.valid_o || fi.data_out != m_hold_data || fi.lane_valid_i != m_hold_lanes))
      d[1] = 1'b1;
    if (fi.must_flush && fi.valid_o) d[2] = 1'b1;
    pc   = $countones(fi.lane_valid_i);
    hole = (pc == 0) || (int'(fi.lane_valid_i) != ((1 << pc) - 1));
    if (fi.valid_o && hole) d[3] = 1'b1;
    if (m_err == 4'b0 && d != 4'b0) begin
      m_first     = d;
      m_first_cyc = m_cyc;
    end
    m_err = m_err | d;
    m_cyc = sat(m_cyc + 1);
    xf = fi.valid_o && fi.ready_in;
    st = fi.valid_o && !fi.ready_in;
    m_evt[0] = sat(m_evt[0] + int'(fi.must_flush));
    m_evt[1] = sat(m_evt[1] + int'(fi.invalid_prediction));
    m_evt[2] = sat(m_evt[2] + int'(fi.invalid_instruction));
    m_evt[3] = sat(m_evt[3] + int'(fi.is_jumpl));
    m_evt[4] = sat(m_evt[4] + int'(fi.is_return_in));
    m_evt[5] = sat(m_evt[5] + int'(xf));
    m_evt[6] = sat(m_evt[6] + int'(st));
    m_evt[7] = sat(m_evt[7] + (xf ? pc : 0));
    m_cov[0] = sat(m_cov[0] + int'(fi.must_flush && fi.miss));
    m_cov[1] = sat(m_cov[1] + int'(fi.invalid_prediction && fi.miss));
    m_cov[2] = sat(m_cov[2] + int'(fi.invalid_instruction && fi.miss));
    for (int t = 1; t <= 3; t++)
      m_cov[2+t] = sat(m_cov[2+t] + int'(fi.partial_access && fi.hit_cache && fi.partial_type == 2'(t)));
    if (st) begin
      m_hold_data  = fi.data_out;
      m_hold_lanes = fi.lane_valid_i;
    end
    m_hold_vld = st && !fi.must_flush;
  endtask

  // One clock: model advances at the edge, outputs are then read at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clear_i = 1'b0;
    fi.valid_o = 0; fi.ready_in = 0; fi.data_out = '0; fi.lane_valid_i = '0;
    fi.must_flush = 0; fi.invalid_prediction = 0; fi.invalid_instruction = 0;
    fi.is_return_in = 0; fi.is_jumpl = 0; fi.hit_cache = 0; fi.miss = 0;
    fi.partial_access = 0; fi.partial_type = '0;
    fs.valid_o = 0; fs.ready_in = 0; fs.data_out = '0; fs.lane_valid_i = '0;
    fs.must_flush = 0; fs.invalid_prediction = 0; fs.invalid_instruction = 0;
    fs.is_return_in = 0; fs.is_jumpl = 0; fs.hit_cache = 0; fs.miss = 0;
    fs.partial_access = 0; fs.partial_type = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    cycle();
    cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    model_reset();
    cycle();
    n_cmp++;
    if ({err_flags, err_any, first_err, first_cyc} !== 25'd0) begin
      n_bad++; $display("FAIL reset_err: got %h want 0", {err_flags, err_any, first_err, first_cyc});
    end
    n_cmp++;
    if ({evt, cov} !== 224'd0) begin
      n_bad++; $display("FAIL reset_cnt: got %h want 0", {evt, cov});
    end
    n_cmp++;
    if ({s_err_flags, s_err_any, s_first_err, s_first_cyc, s_evt, s_cov} !== 69'd0) begin
      n_bad++; $display("FAIL reset_small: got %h want 0", {s_err_flags, s_first_err, s_evt, s_cov});
    end
    rst = 1'b0;
  endtask

  task automatic test_restart_multi();
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    fi.invalid_prediction = 1; fi.is_return_in = 1;
    cycle();
    idle_inputs();
    n_cmp++;
    if (err_flags !== 4'b0001) begin
      n_bad++; $display("FAIL restart_flags: got %b want 0001", err_flags);
    end
    n_cmp++;
    if (first_cyc !== 16'd5 || first_err !== 4'b0001) begin
      n_bad++; $display("FAIL restart_first: got cyc=%0d err=%b want cyc=5 err=0001", first_cyc, first_err);
    end
    cycle();
    fi.valid_o = 1; fi.ready_in = 1; fi.must_flush = 1; fi.lane_valid_i = 2'b01;
    cycle();
    idle_inputs();
    n_cmp++;
    if (err_flags !== 4'b0101 || first_err !== 4'b0001 || first_cyc !== 16'd5) begin
      n_bad++; $display("FAIL restart_later: got flags=%b first=%b cyc=%0d want 0101/0001/5",
                        err_flags, first_err, first_cyc);
    end
  endtask

  task automatic test_valid_unstable();
    do_reset();
    fi.valid_o = 1; fi.ready_in = 0; fi.lane_valid_i = 2'b11; fi.data_out = 128'hA;
    cycle();
    fi.data_out = 128'hB;
    cycle();
    idle_inputs();
    n_cmp++;
    if (err_flags !== 4'b0010 || !err_any) begin
      n_bad++; $display("FAIL unstable_set: got %b any=%b want 0010 any=1", err_flags, err_any);
    end
    do_reset();
    fi.valid_o = 1; fi.ready_in = 0; fi.lane_valid_i = 2'b11; fi.data_out = 128'hA;
    cycle();
    fi.data_out = 128'hB; fi.must_flush = 1;
    cycle();
    fi.must_flush = 0; fi.ready_in = 1; fi.data_out = 128'hC;
    cycle();
    idle_inputs();
    n_cmp++;
    if (err_flags !== 4'b0100) begin
      n_bad++; $display("FAIL unstable_flush_exempt: got %b want 0100", err_flags);
    end
  endtask

  task automatic test_lane_hole();
    do_reset();
    fi.valid_o = 1; fi.ready_in = 1; fi.lane_valid_i = 2'b10;
    fs.valid_o = 1; fs.ready_in = 1; fs.lane_valid_i = 4'b0111;
    cycle();
    idle_inputs();
    n_cmp++;
    if (err_flags !== 4'b1000 || s_err_flags !== 4'b0000) begin
      n_bad++; $display("FAIL hole_10_0111: got main=%b small=%b want 1000/0000", err_flags, s_err_flags);
    end
    clear_i = 1;
    cycle();
    clear_i = 0;
    fi.valid_o = 1; fi.ready_in = 1; fi.lane_valid_i = 2'b00;
    fs.valid_o = 1; fs.ready_in = 1; fs.lane_valid_i = 4'b0101;
    cycle();
    idle_inputs();
    n_cmp++;
    if (err_flags !== 4'b1000 || s_err_flags !== 4'b1000) begin
      n_bad++; $display("FAIL hole_00_0101: got main=%b small=%b want 1000/1000", err_flags, s_err_flags);
    end
  endtask

  task automatic test_counters();
    do_reset();
    fi.valid_o = 1; fi.ready_in = 0; fi.lane_valid_i = 2'b11; fi.data_out = 128'h1234;
    for (int i = 0; i < 3; i++) cycle();
    fi.ready_in = 1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      fi.data_out = {$urandom, $urandom, $urandom, $urandom};
    end
    idle_inputs();
    cycle();
    n_cmp++;
    if (evt[5*16 +: 16] !== 16'd10 || evt[6*16 +: 16] !== 16'd3 || evt[7*16 +: 16] !== 16'd20) begin
      n_bad++; $display("FAIL xfer_counts: got xfer=%0d stall=%0d lanes=%0d want 10/3/20",
                        evt[5*16 +: 16], evt[6*16 +: 16], evt[7*16 +: 16]);
    end
    n_cmp++;
    if (err_flags !== 4'b0000) begin
      n_bad++; $display("FAIL xfer_noerr: got %b want 0000", err_flags);
    end
  endtask

  task automatic test_saturation_clear();
    do_reset();
    fi.must_flush = 1; fs.must_flush = 1;
    for (int i = 0; i < 20; i++) cycle();
    idle_inputs();
    n_cmp++;
    if (s_evt[3:0] !== 4'd15 || evt[15:0] !== 16'd20) begin
      n_bad++; $display("FAIL flush_saturate: got small=%0d main=%0d want 15/20", s_evt[3:0], evt[15:0]);
    end
    fi.invalid_prediction = 1; fi.invalid_instruction = 1;
    fi.valid_o = 1; fi.ready_in = 1; fi.must_flush = 1; fi.lane_valid_i = 2'b11;
    cycle();
    clear_i = 1;
    cycle();
    idle_inputs();
    n_cmp++;
    if ({err_flags, first_err, first_cyc} !== 24'd0 || evt !== 128'd0 || s_evt !== 32'd0) begin
      n_bad++; $display("FAIL clear_priority: got flags=%b first=%b cyc=%0d evt=%h sevt=%h want all 0",
                        err_flags, first_err, first_cyc, evt, s_evt);
    end
  endtask

  task automatic test_cover();
    logic [15:0] exp0, exp4;
    do_reset();
    fi.miss = 1; fi.must_flush = 1;
    cycle();
    cycle();
    idle_inputs();
    fi.partial_access = 1; fi.hit_cache = 1; fi.partial_type = 2'd2;
    cycle();
    idle_inputs();
`ifdef IFMON_COVER_EN
    exp0 = 16'd2; exp4 = 16'd1;
`else
    exp0 = 16'd0; exp4 = 16'd0;
`endif
    n_cmp++;
    if (cov[15:0] !== exp0) begin
      n_bad++; $display("FAIL cov_flush_miss: got %0d want %0d", cov[15:0], exp0);
    end
    n_cmp++;
    if (cov[4*16 +: 16] !== exp4 || cov[3*16 +: 16] !== 16'd0 || cov[5*16 +: 16] !== 16'd0) begin
      n_bad++; $display("FAIL cov_partial: got %h want p2=%0d others 0", cov, exp4);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    fi.valid_o = 1; fi.ready_in = 1; fi.lane_valid_i = 2'b01; fi.data_out = 128'h55;
    for (int i = 0; i < 3; i++) cycle();
    fi.ready_in = 0;
    cycle();
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({err_flags, err_any, first_err, first_cyc} !== 25'd0 || {evt, cov} !== 224'd0) begin
      n_bad++; $display("FAIL async_reset: got flags=%b evt=%h cov=%h want all 0", err_flags, evt, cov);
    end
    cycle();
    rst = 1'b0;
    fi.data_out = 128'h66;
    cycle();
    idle_inputs();
    n_cmp++;
    if (err_flags !== 4'b0000) begin
      n_bad++; $display("FAIL async_restart_clean: got %b want 0000", err_flags);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 600; n++) begin
      idle_inputs();
      if (m_hold_vld && $urandom_range(0, 99) < 85) begin
        fi.valid_o = 1; fi.data_out = m_hold_data; fi.lane_valid_i = m_hold_lanes;
      end else begin
        fi.valid_o = ($urandom_range(0, 99) < 70);
        fi.data_out = {$urandom, $urandom, $urandom, $urandom};
        fi.lane_valid_i = ($urandom_range(0, 99) < 80) ? 2'b11 : 2'($urandom);
      end
      fi.ready_in            = ($urandom_range(0, 99) < 60);
      fi.must_flush          = ($urandom_range(0, 99) < 8);
      fi.invalid_prediction  = ($urandom_range(0, 99) < 10);
      fi.invalid_instruction = ($urandom_range(0, 99) < 10);
      fi.is_return_in        = ($urandom_range(0, 99) < 10);
      fi.is_jumpl            = ($urandom_range(0, 99) < 15);
      fi.hit_cache           = ($urandom_range(0, 99) < 50);
      fi.miss                = ($urandom_range(0, 99) < 30);
      fi.partial_access      = ($urandom_range(0, 99) < 40);
      fi.partial_type        = 2'($urandom);
      clear_i                = ($urandom_range(0, 99) < 3);
      cycle();
      n_cmp++;
      if (err_flags !== m_err || err_any !== (m_err != 4'b0)) begin
        n_bad++; $display("FAIL rnd_flags @%0d: got %b/%b want %b", n, err_flags, err_any, m_err);
      end
      n_cmp++;
      if (first_err !== m_first || first_cyc !== 16'(m_first_cyc)) begin
        n_bad++; $display("FAIL rnd_first @%0d: got %b/%0d want %b/%0d", n, first_err, first_cyc, m_first, m_first_cyc);
      end
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (evt[k*16 +: 16] !== 16'(m_evt[k])) begin
          n_bad++; $display("FAIL rnd_evt%0d @%0d: got %0d want %0d", k, n, evt[k*16 +: 16], m_evt[k]);
        end
      end
      for (int k = 0; k < 6; k++) begin
        n_cmp++;
`ifdef IFMON_COVER_EN
        if (cov[k*16 +: 16] !== 16'(m_cov[k])) begin
          n_bad++; $display("FAIL rnd_cov%0d @%0d: got %0d want %0d", k, n, cov[k*16 +: 16], m_cov[k]);
        end
`else
        if (cov[k*16 +: 16] !== 16'd0) begin
          n_bad++; $display("FAIL rnd_cov%0d @%0d: got %0d want 0", k, n, cov[k*16 +: 16]);
        end
`endif
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    @(negedge clk);
    test_reset();
    test_restart_multi();
    test_valid_unstable();
    test_lane_hole();
    test_counters();
    test_saturation_clear();
    test_cover();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
